// File: rtl/hiscore_pkg.sv
// Shared definitions for the hiscore ioctl master: FSM state encoding,
// ioctl index constants and the 25-bit address type.
package hiscore_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DL_WAIT = 3'd1,
        DL_WR   = 3'd2,
        DL_GAP  = 3'd3,
        UL_SET  = 3'd4,
        UL_WAIT = 3'd5,
        UL_PUSH = 3'd6,
        DONE    = 3'd7
    } hs_state_t;

    localparam logic [7:0] HS_IDX_CONFIG = 8'd3;
    localparam logic [7:0] HS_IDX_DUMP   = 8'd4;

    typedef logic [24:0] hs_addr_t;

endpackage

// File: rtl/hiscore_ioctl_gap_timer.sv
// 4-bit self-decrementing down-counter; load a value, o_zero flags expiry.
module hiscore_ioctl_gap_timer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_value,
    output logic       o_zero
);

    logic [3:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/hiscore_ioctl_master.sv
// Byte-serial ioctl master: downloads tx bytes into ioctl_wr pulses, uploads
// ioctl_din bytes to rx. Optional feature macro: HISCORE_IOCTL_CHECKSUM_EN.
module hiscore_ioctl_master
    import hiscore_pkg::*;
#(
    parameter int unsigned WR_GAP = 3,
    parameter int unsigned RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_upload,
    input  logic [7:0]  cmd_index,
    input  logic [24:0] cmd_length,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        ioctl_download,
    output logic        ioctl_upload,
    output logic        ioctl_wr,
    output logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_dout,
    output logic [7:0]  ioctl_index,
    input  logic [7:0]  ioctl_din,
    output logic        busy
`ifdef HISCORE_IOCTL_CHECKSUM_EN
    ,
    output logic [7:0]  checksum
`endif
);

    localparam logic [3:0] GAP_LOAD = (WR_GAP > 0) ? 4'(WR_GAP - 1) : '0;
    localparam logic [3:0] RD_LOAD  = (RD_LAT > 1) ? 4'(RD_LAT - 2) : '0;

    hs_state_t  r_state;
    logic       r_alive;
    hs_addr_t   r_addr;
    hs_addr_t   r_len;
    logic [7:0] r_dout;
    logic [7:0] r_index;
    logic [7:0] r_rx_data;

    logic       w_accept;
    logic       w_last;
    logic       w_zero_len;
    logic       w_tx_take;
    logic       w_rx_capture;
    logic       w_dl_step;
    logic       w_tmr_load;
    logic [3:0] w_tmr_value;
    logic       w_tmr_zero;

    hiscore_ioctl_gap_timer u_gap_timer (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_zero  (w_tmr_zero)
    );

    assign cmd_ready      = r_alive && (r_state == IDLE);
    assign busy           = (r_state != IDLE);
    assign ioctl_download = (r_state == DL_WAIT) || (r_state == DL_WR) || (r_state == DL_GAP);
    assign ioctl_upload   = (r_state == UL_SET) || (r_state == UL_WAIT) || (r_state == UL_PUSH);
    assign ioctl_wr       = (r_state == DL_WR);
    assign ioctl_addr     = r_addr;
    assign ioctl_dout     = r_dout;
    assign ioctl_index    = r_index;
    assign rx_valid       = (r_state == UL_PUSH);
    assign rx_data        = r_rx_data;

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_zero_len = (r_len == '0);
    assign w_last     = (r_addr == r_len - 25'd1);
    // A zero-length command still spends one cycle in the first transfer state
    // so download/upload is seen high before DONE drops it.
    assign tx_ready   = (r_state == DL_WAIT) && !w_zero_len;
    assign w_tx_take  = tx_ready && tx_valid;

    assign w_rx_capture = ((r_state == UL_SET) && !w_zero_len && (RD_LAT <= 1)) ||
                          ((r_state == UL_WAIT) && w_tmr_zero);
    assign w_dl_step    = ((r_state == DL_WR) && (WR_GAP == 0)) ||
                          ((r_state == DL_GAP) && w_tmr_zero);

    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        if ((r_state == DL_WR) && (WR_GAP > 0)) begin
            w_tmr_load  = 1'b1;
            w_tmr_value = GAP_LOAD;
        end else if ((r_state == UL_SET) && (RD_LAT > 1)) begin
            w_tmr_load  = 1'b1;
            w_tmr_value = RD_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_alive   <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_dout    <= '0;
            r_index   <= '0;
            r_rx_data <= '0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_len   <= cmd_length;
                        r_addr  <= '0;
                        r_index <= cmd_index;
                        r_state <= cmd_upload ? UL_SET : DL_WAIT;
                    end
                end
                DL_WAIT: begin
                    if (w_zero_len) begin
                        r_state <= DONE;
                    end else if (w_tx_take) begin
                        r_dout  <= tx_data;
                        r_state <= DL_WR;
                    end
                end
                DL_WR, DL_GAP: begin
                    if (w_dl_step) begin
                        if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            r_addr  <= r_addr + 25'd1;
                            r_state <= DL_WAIT;
                        end
                    end else begin
                        r_state <= DL_GAP;
                    end
                end
                UL_SET, UL_WAIT: begin
                    if ((r_state == UL_SET) && w_zero_len) begin
                        r_state <= DONE;
                    end else if (w_rx_capture) begin
                        r_rx_data <= ioctl_din;
                        r_state   <= UL_PUSH;
                    end else begin
                        r_state <= UL_WAIT;
                    end
                end
                UL_PUSH: begin
                    if (rx_ready) begin
                        if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            r_addr  <= r_addr + 25'd1;
                            r_state <= UL_SET;
                        end
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef HISCORE_IOCTL_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= '0;
        end else if (w_tx_take) begin
            r_csum <= r_csum + tx_data;
        end else if (w_rx_capture) begin
            r_csum <= r_csum + ioctl_din;
        end
    end

    assign checksum = r_csum;
`endif

endmodule

// File: doc/hiscore_ioctl_master.md
HISCORE_IOCTL_MASTER -- requirements
Module: hiscore_ioctl_master

Interface
REQ-001 SHALL have parameter WR_GAP, default 3: idle cycles after each ioctl_wr pulse before the next byte; range 0..15.
REQ-002 SHALL have parameter RD_LAT, default 2: cycles from an ioctl_addr change to valid ioctl_din; range 1..7.
REQ-003 SHALL have port clk, input, 1: the single clock for the block.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake.
REQ-006 SHALL have ports cmd_upload (input, 1; 0=download, 1=upload), cmd_index (input, 8) and cmd_length (input, 25; byte count).
REQ-007 SHALL have ports tx_valid (input, 1), tx_data (input, 8) and tx_ready (output, 1): byte source for downloads.
REQ-008 SHALL have ports rx_valid (output, 1), rx_data (output, 8) and rx_ready (input, 1): byte sink for uploads.
REQ-009 SHALL have outputs ioctl_download (1), ioctl_upload (1), ioctl_wr (1), ioctl_addr (25), ioctl_dout (8) and ioctl_index (8), and input ioctl_din (8).
REQ-010 SHALL have output busy (1): high in any state except IDLE.

Function
REQ-011 SHALL use FSM states IDLE, DL_WAIT, DL_WR, DL_GAP, UL_SET, UL_WAIT, UL_PUSH and DONE.
REQ-012 IDLE: cmd_ready=1; on cmd_valid, SHALL latch index/length/direction, set ioctl_addr=0 and ioctl_index=cmd_index, and go to DL_WAIT or UL_SET; go to DONE if length=0.
REQ-013 SHALL hold ioctl_download/ioctl_upload high from the cycle after acceptance until DONE is entered, per the latched direction.
REQ-014 DL_WAIT: tx_ready=1; on tx_valid, SHALL register tx_data into ioctl_dout and go to DL_WR.
REQ-015 DL_WR: ioctl_wr=1 for exactly one cycle with ioctl_addr and ioctl_dout stable, then go to DL_GAP.
REQ-016 DL_GAP: SHALL wait WR_GAP cycles, then increment ioctl_addr; go to DONE if the last byte was sent, else to DL_WAIT.
REQ-017 ioctl_dout and ioctl_addr SHALL change only outside the DL_WR cycle.
REQ-018 UL_SET/UL_WAIT: ioctl_addr SHALL be held stable for RD_LAT cycles, then ioctl_din is registered into rx_data and the FSM goes to UL_PUSH.
REQ-019 UL_PUSH: rx_valid=1 with rx_data stable until rx_ready; on handshake, increment ioctl_addr and go to UL_SET, or to DONE after the last byte.
REQ-020 DONE: ioctl_download and ioctl_upload SHALL be low, ioctl_index held for exactly one cycle, then return to IDLE. This guarantees the falling edge of download is seen with the index still valid.
REQ-021 ioctl_index SHALL be unchanged from acceptance through DONE; in IDLE it retains its last value.
REQ-022 The byte counter SHALL be 25 bits; ioctl_addr never exceeds cmd_length-1; no wrap-around occurs.
REQ-023 cmd_valid while busy SHALL be ignored (cmd_ready=0); it is not queued.
REQ-024 tx_valid outside DL_WAIT and rx_ready outside UL_PUSH SHALL have no effect.

Reset
REQ-025 reset_n low SHALL immediately force IDLE with all ioctl_* outputs 0 and rx_valid=0, tx_ready=0, cmd_ready=0.
REQ-026 While reset_n is low, cmd_ready=0 and busy=0; cmd_ready=1 from the first clock after release.
REQ-027 Reset mid-transfer SHALL abort the transfer with no DONE cycle; the partial transfer is discarded.

Configuration
REQ-028 With HISCORE_IOCTL_CHECKSUM_EN defined: output checksum (8) SHALL be the modulo-256 sum of all transferred bytes, cleared on command acceptance and valid from DONE until the next acceptance.
REQ-029 Without HISCORE_IOCTL_CHECKSUM_EN: no checksum port and no checksum logic.

Structure
REQ-030 A shared package hiscore_pkg SHALL hold the state enum, the ioctl index constants (HS_IDX_CONFIG=3, HS_IDX_DUMP=4) and the 25-bit address type.
REQ-031 SHALL contain one sub-module, hiscore_ioctl_gap_timer: a 4-bit down-counter shared by the WR_GAP and RD_LAT waits.

Verification
REQ-032 Download: index 3, length 8, bytes 00 00 00 0B 0F 10 01 00 -> eight 1-cycle ioctl_wr pulses at addr 0..7, each 1+WR_GAP cycles apart; download falls with index=3 held.
REQ-033 Upload: length 4, memory model returning addr+0x40 after RD_LAT=2 -> rx_data 40,41,42,43; rx_ready stalled 5 cycles holds ioctl_addr and rx_data stable.
REQ-034 Length 0, download -> download high for 1 cycle, no ioctl_wr, then DONE and back to IDLE.
REQ-035 reset_n pulsed low at byte 3 of 8 -> all outputs 0 within the reset period, no DONE cycle; a new command is accepted afterward starting at ioctl_addr=0.
REQ-036 cmd_valid asserted while busy -> ignored, cmd_ready=0; with HISCORE_IOCTL_CHECKSUM_EN, bytes 01 FF 02 -> checksum 02.
